mac_dot: RTL and testbench

Parametrised, pipelined signed fixed-point multiply-accumulate engine; the next-generation replacement for the single-product mac in the neuron datapath. Accepts one (a, b) operand pair per enabled cycle and accumulates LEN products at full precision. It then emits one rescaled DATA_W-bit dot-product result with a one-cycle valid strobe. Back-to-back dot products stream with no bubble cycles.

---
 rtl/mac_dot.sv | 106 ++++++++++
 tb/tb_mac_dot.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot.sv
// Signed fixed-point dot-product MAC: LEN products accumulated at full precision, rescaled to DATA_W (MAC_SAT_EN: saturate, else wrap).
// Latency: result registered one edge after the last product leaves the multiplier stage; one pair per cycle, no bubbles.
// Backpressure: none; enable is a pure valid, gaps hold the partial sum, clear flushes it.
module mac_dot #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 7,
    parameter int LEN    = 4,
    localparam int ACC_W = 2*DATA_W + $clog2(LEN),
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] out,
    output logic                     out_valid,
    output logic [CNT_W-1:0]         cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

    logic signed [2*DATA_W-1:0] p_q, p_d;
    logic                       pv_q, pv_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [DATA_W-1:0]   out_q, out_d;
    logic                       ov_q, ov_d;

    logic signed [ACC_W-1:0]    sum;
    logic signed [DATA_W-1:0]   fmt;

    assign sum = acc_q + ACC_W'(p_q);

`ifdef MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic signed [ACC_W-1:0] shr;

    assign shr = sum >>> FRAC_W;
    assign fmt = (shr > SAT_MAX) ? {1'b0, {(DATA_W-1){1'b1}}} :
                 (shr < SAT_MIN) ? {1'b1, {(DATA_W-1){1'b0}}} :
                                   shr[DATA_W-1:0];
`else
    assign fmt = DATA_W'(sum >>> FRAC_W);
`endif

    always_comb begin
        p_d   = p_q;
        pv_d  = 1'b0;
        acc_d = acc_q;
        cnt_d = cnt_q;
        out_d = out_q;
        ov_d  = 1'b0;

        if (enable) begin
            p_d  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
            pv_d = 1'b1;
        end

        if (pv_q) begin
            if (cnt_q == LAST) begin
                out_d = fmt;
                ov_d  = 1'b1;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // clear also kills a completion landing on this same edge
        if (clear) begin
            pv_d  = 1'b0;
            acc_d = '0;
            cnt_d = '0;
            ov_d  = 1'b0;
            out_d = out_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_q   <= '0;
            pv_q  <= 1'b0;
            acc_q <= '0;
            cnt_q <= '0;
            out_q <= '0;
            ov_q  <= 1'b0;
        end else begin
            p_q   <= p_d;
            pv_q  <= pv_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            out_q <= out_d;
            ov_q  <= ov_d;
        end
    end

    assign out       = out_q;
    assign out_valid = ov_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_mac_dot.sv
// Randomised + directed bench for mac_dot; a reference model computes each dot product from its operand list.
module tb_mac_dot;

    localparam int DATA_W = 8;
    localparam int FRAC_W = 7;
    localparam int LEN    = 4;
    localparam int CNT_W  = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     enable;
    logic                     clear;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic signed [DATA_W-1:0] out;
    logic                     out_valid;
    logic [CNT_W-1:0]         cnt;

    mac_dot #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .LEN(LEN)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear),
        .a         (a),
        .b         (b),
        .out       (out),
        .out_valid (out_valid),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int ecyc;
    } exp_t;

    exp_t   sb[$];
    longint cur[$];
    int     cyc = 0;
    int     nsamp = 0;
    int     last_samp = 0;
    int     last_out = 0;
    int     checks = 0;
    int     errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int fmt_ref(input longint s);
        longint q, r, span, half, div;
        span = longint'(1) << DATA_W;
        half = span / 2;
        div  = longint'(1) << FRAC_W;
        q = s / div;
        if (s < 0 && (s % div) != 0) q = q - 1;
`ifdef MAC_SAT_EN
        if (q > half - 1) q = half - 1;
        if (q < -half) q = -half;
        return int'(q);
`else
        r = q % span;
        if (r < 0) r = r + span;
        if (r >= half) r = r - span;
        return int'(r);
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock edge of stimulus; the model advances as the pair is handed to the DUT.
    task automatic step(input bit en, input int x, input int y, input bit clr);
        logic signed [DATA_W-1:0] xa, yb;
        longint s;
        xa = x[DATA_W-1:0];
        yb = y[DATA_W-1:0];
        @(negedge clk);
        chk("cnt", int'(cnt), (nsamp - last_samp) % LEN);
        enable = en;
        clear  = clr;
        a      = xa;
        b      = yb;
        if (clr) begin
            nsamp = 0;
            last_samp = 0;
            cur.delete();
            if (sb.size() > 0 && sb[$].ecyc == cyc + 1) void'(sb.pop_back());
        end else if (en) begin
            nsamp++;
            last_samp = 1;
            cur.push_back(longint'(xa) * longint'(yb));
            if (cur.size() == LEN) begin
                s = 0;
                foreach (cur[i]) s += cur[i];
                sb.push_back('{val: fmt_ref(s), ecyc: cyc + 2});
                cur.delete();
            end
        end else begin
            last_samp = 0;
        end
    endtask

    task automatic pr(input int x, input int y);
        step(1'b1, x, y, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset  = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        sb.delete();
        cur.delete();
        nsamp = 0;
        last_samp = 0;
        last_out = 0;
        #1;
        chk("rst_out", int'(out), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_cnt", int'(cnt), 0);
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            while (sb.size() > 0 && sb[0].ecyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_result: got no out_valid expected out=%0d at cycle %0d", sb[0].val, sb[0].ecyc);
                void'(sb.pop_front());
            end
            if (out_valid) begin
                if (sb.size() == 0 || sb[0].ecyc != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got out_valid=1 out=%0d expected no result (cycle %0d)", out, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("out", int'(out), e.val);
                    last_out = e.val;
                end
            end else begin
                chk("out_hold", int'(out), last_out);
            end
        end
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout expected run to finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        clear  = 1'b0;
        a      = '0;
        b      = '0;
        #12;
        chk("init_out", int'(out), 0);
        chk("init_valid", int'(out_valid), 0);
        chk("init_cnt", int'(cnt), 0);
        @(negedge clk);
        #1 reset = 1'b1;

        pr(8'h71, 8'h51); pr(4, 10); pr(12, 2); pr(2, 3);
        idle(3);

        pr(1, -1); pr(-1, 1); pr(-1, -2); pr(-20, 2);
        for (int i = 0; i < 4; i++) pr(-7, -2);
        idle(3);

        for (int i = 0; i < 4; i++) pr(127, 127);
        for (int i = 0; i < 4; i++) pr(-128, -128);
        for (int i = 0; i < 4; i++) pr(-128, 127);
        idle(3);

        pr(4, 10); pr(12, 2);
        idle(10);
        pr(2, 3); pr(8'h71, 8'h51);
        idle(3);

        for (int i = 0; i < 3; i++) pr(4, 10);
        step(1'b1, 4, 10, 1'b1);
        for (int i = 0; i < 4; i++) pr(1, 1);
        idle(3);

        for (int i = 0; i < 4; i++) pr(4, 10);
        step(1'b0, 0, 0, 1'b1);
        idle(3);

        for (int i = 0; i < 3; i++) pr(2, 3);
        async_reset();
        for (int i = 0; i < 4; i++) pr(2, 3);
        idle(4);

        for (int n = 0; n < 800; n++) begin
            int r;
            r = int'($urandom_range(0, 199));
            if (r == 199) async_reset();
            else if (r < 8) step(1'b1, int'($urandom), int'($urandom), 1'b1);
            else if (r < 150) step(1'b1, int'($urandom), int'($urandom), 1'b0);
            else step(1'b0, 0, 0, 1'b0);
        end
        idle(6);
        chk("drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
